draw_text_rect: RTL and testbench
=================================

# draw_text_rect

Text-overlay stage for the VGA pixel pipeline, acting as the reading side of the text-ROM interface. For each pixel it computes which character cell of a fixed on-screen rectangle is being scanned and presents that cell's `char_xy` address to an external text ROM. It then reads the font row for the returned character, and replaces the incoming RGB with a foreground colour wherever a glyph pixel is set. It sits between the background/sprite drawing stages and the VGA output register.

## Interface
- `XPOS`, 0: left pixel column of the text rectangle.
- `YPOS`, 0: top pixel row of the text rectangle.
- `COLS`, 16: characters per row, 1..16.
- `ROWS`, 1: character rows, 1..16.
- `FG_COLOR`, 12'hFFF: RGB444 colour for set glyph pixels.
- `BLINK_FRAMES`, 30: frames per blink phase; used only with `TEXT_BLINK_EN`.

- `pclk`, in, 1: pixel clock; all logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `hcount_in`, `vcount_in`, in, 11 each: pixel position.
- `hsync_in`, `vsync_in`, `hblnk_in`, `vblnk_in`, in, 1 each: timing signals.
- `rgb_in`, in, 12: upstream colour.
- `char_xy`, out, 8: text ROM address `{row[3:0], col[3:0]}`; registered.
- `char_line`, out, 4: glyph row 0..15; registered and aligned with `char_xy`.
- `char_pixels`, in, 8: font row returned by the external font ROM. Bit 7 is the leftmost pixel.
- `hcount_out`, `vcount_out`, `hsync_out`, `vsync_out`, `hblnk_out`, `vblnk_out`, `rgb_out`, out: delayed timing and the resulting colour.

## Operation
- The character cell is 8×16 pixels.
  - `rel_x = hcount_in - XPOS`, `rel_y = vcount_in - YPOS`; both are 11-bit unsigned.
  - `in_rect` is true when `hcount_in >= XPOS`, `hcount_in < XPOS+8*COLS`, `vcount_in >= YPOS` and `vcount_in < YPOS+16*ROWS`.
- Stage 1 registers:
  - `char_xy = {rel_y[7:4], rel_x[6:3]}` and `char_line = rel_y[3:0]` when `in_rect`; otherwise both are 0.
  - Also captured in this stage: `bit_sel = rel_x[2:0]`, `in_rect`, and all timing and `rgb` inputs.
- External path: the text ROM is combinational and produces `char_code`. The font ROM is registered and takes the address `{char_code, char_line}`. Therefore `char_pixels` corresponds to the stage-1 address one cycle later, i.e. at stage 2.
- Stage 2 carries `bit_sel`, `in_rect`, timing and `rgb` forward one more cycle.
- Stage 3 (output register):
  - Define `pix_on = in_rect_s2 & char_pixels[7-bit_sel_s2] & ~hblnk_s2 & ~vblnk_s2 & ~blink_off`.
  - `rgb_out = pix_on ? FG_COLOR : rgb_s2`.
  - Timing outputs are the stage-2 values.
- Outside the rectangle and during blanking, `rgb_out` equals `rgb_in` delayed by 3 cycles.
- Without the blink feature, `blink_off` is constant 0.

## Timing
- Latency is exactly 3 `pclk` cycles from every input to every output, with no bubbles. Throughput is one pixel per cycle.
- Reset values: every output is 0, and all pipeline registers and the blink state are 0.
- A reset asserted mid-frame clears the pipeline on that edge. The first valid output appears 3 cycles after `rst` is deasserted.
- Rectangle boundaries are inclusive/exclusive:
  - `hcount_in = XPOS+8*COLS-1` is inside; `XPOS+8*COLS` is outside.
  - Vertical boundaries follow the same rule.
- Upstream must guarantee `XPOS+8*COLS` and `YPOS+16*ROWS` are ≤ 2047. There is no wrap handling.

## Configuration
- `TEXT_BLINK_EN` defined:
  - A frame counter (width `$clog2(BLINK_FRAMES)`) increments on each rising edge of `vsync_in`. The edge is detected against a registered copy of `vsync_in`.
  - At `BLINK_FRAMES-1` the counter wraps to 0 and `blink_off` toggles.
  - `blink_off` suppresses glyph pixels only; timing and background pass through unchanged.
  - Reset sets the counter to 0 and `blink_off` to 0, so text is visible.
- `TEXT_BLINK_EN` undefined: no counter or edge detector is built, and text is always shown.

## Test plan
- Reset behaviour: hold `rst` for 2 cycles with random inputs → all outputs are 0. After release, `hcount_out` follows `hcount_in` with exactly 3 cycles of delay.
- Address generation: with `XPOS=100`, `YPOS=50`, `COLS=5`, drive `hcount_in=117`, `vcount_in=53` → next cycle `char_xy=8'h02`, `char_line=4'd3`. Drive `hcount_in=140` (outside) → `char_xy=0`.
- Glyph pixel: at `hcount_in=100` with `char_pixels=8'h80` returned at stage 2 → `rgb_out=FG_COLOR` 3 cycles later. At `hcount_in=101` with the same font row → `rgb_out` equals the delayed `rgb_in`.
- Boundary: `hcount_in=139` is inside and `140` is outside with `char_pixels=8'hFF` → `FG_COLOR` at 139, passthrough at 140.
- Blanking and mid-frame reset: `hblnk_in=1` inside the rectangle with `char_pixels=8'hFF` → passthrough `rgb`. Assert `rst` mid-line → outputs are 0 on the next edge.
- Blink (`TEXT_BLINK_EN`, `BLINK_FRAMES=2`): after 2 `vsync` rising edges, glyph pixels are suppressed. After 2 more, they reappear.

Source files
------------

// File: rtl/draw_text_rect.sv
// -----------------------------------------------------------------------------
// draw_text_rect
//
// Text-overlay stage of the VGA pixel pipeline. For each pixel it works out
// which 8x16 character cell of a fixed on-screen rectangle is being scanned,
// presents that cell's address to an external (combinational) text ROM, and
// one cycle later receives the matching font row from an external registered
// font ROM. Wherever the selected glyph bit is set, the incoming colour is
// replaced by FG_COLOR. Latency is exactly 3 pclk cycles, one pixel per cycle.
//
// Optional feature: define TEXT_BLINK_EN to build a vsync-driven frame counter
// that toggles text visibility every BLINK_FRAMES frames.
//
// Parameters
//   XPOS, YPOS    top-left pixel of the text rectangle
//   COLS, ROWS    rectangle size in characters (1..16 each)
//   FG_COLOR      RGB444 colour of set glyph pixels
//   BLINK_FRAMES  frames per blink phase (TEXT_BLINK_EN only)
//
// Ports
//   pclk, rst                          pixel clock, synchronous active-high reset
//   hcount_in, vcount_in               pixel position (11 bit)
//   hsync_in, vsync_in,
//   hblnk_in, vblnk_in                 timing signals
//   rgb_in                             upstream colour (RGB444)
//   char_xy                            text ROM address {row, col}, stage 1
//   char_line                          glyph row 0..15, aligned with char_xy
//   char_pixels                        font row from font ROM (bit 7 = leftmost)
//   hcount_out .. vblnk_out, rgb_out   timing and colour, delayed 3 cycles
// -----------------------------------------------------------------------------
module draw_text_rect #(
  parameter int unsigned XPOS         = 0,
  parameter int unsigned YPOS         = 0,
  parameter int unsigned COLS         = 16,
  parameter int unsigned ROWS         = 1,
  parameter logic [11:0] FG_COLOR     = 12'hFFF,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [7:0]  char_xy,
  output logic [3:0]  char_line,
  input  logic [7:0]  char_pixels,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam logic [11:0] X0    = 12'(XPOS);
  localparam logic [11:0] Y0    = 12'(YPOS);
  localparam logic [10:0] W_PIX = 11'(8 * COLS);
  localparam logic [10:0] H_PIX = 11'(16 * ROWS);

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } timing_t;

  timing_t     tim_in, tim_s1, tim_s2;
  logic [2:0]  bit_sel_s1, bit_sel_s2;
  logic        in_rect_s1, in_rect_s2;
  logic        blink_off;

  assign tim_in = '{hcount: hcount_in, vcount: vcount_in,
                    hsync: hsync_in, vsync: vsync_in,
                    hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};

  // Offsets are taken one bit wider than the counters: the extra MSB is the
  // borrow, so "left of / above the rectangle" falls out of the subtraction
  // instead of needing a separate >= compare. The low 11 bits are rel_x/rel_y.
  logic [11:0] dx, dy;
  logic        in_rect;

  assign dx      = {1'b0, hcount_in} - X0;
  assign dy      = {1'b0, vcount_in} - Y0;
  assign in_rect = ~dx[11] & (dx[10:0] < W_PIX) &
                   ~dy[11] & (dy[10:0] < H_PIX);

  // ---------------------------------------------------------------------------
  // Stage 1: ROM address and pipeline capture
  // ---------------------------------------------------------------------------
  // NOTE: every pipeline register is cleared by reset so that the outputs read
  // 0 immediately and no stale pixel leaks out after a mid-frame reset.
  always_ff @(posedge pclk) begin
    // NOTE: sequential state is written with <= so every register samples the
    // pre-edge value of its source, independent of statement order.
    if (rst) begin
      char_xy    <= '0;
      char_line  <= '0;
      bit_sel_s1 <= '0;
      in_rect_s1 <= 1'b0;
      tim_s1     <= '0;
    end else begin
      char_xy    <= in_rect ? {dy[7:4], dx[6:3]} : 8'h00;
      char_line  <= in_rect ? dy[3:0] : 4'h0;
      bit_sel_s1 <= dx[2:0];
      in_rect_s1 <= in_rect;
      tim_s1     <= tim_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: wait for the registered font ROM to return char_pixels
  // ---------------------------------------------------------------------------
  always_ff @(posedge pclk) begin
    if (rst) begin
      bit_sel_s2 <= '0;
      in_rect_s2 <= 1'b0;
      tim_s2     <= '0;
    end else begin
      bit_sel_s2 <= bit_sel_s1;
      in_rect_s2 <= in_rect_s1;
      tim_s2     <= tim_s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional blink: frame counter on vsync rising edges
  // ---------------------------------------------------------------------------
`ifdef TEXT_BLINK_EN
  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] frame_cnt;
  logic             vsync_prev;
  logic             blink_q;

  always_ff @(posedge pclk) begin
    if (rst) begin
      frame_cnt  <= '0;
      vsync_prev <= 1'b0;
      blink_q    <= 1'b0;
    end else begin
      vsync_prev <= vsync_in;
      if (vsync_in && !vsync_prev) begin
        if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          blink_q   <= ~blink_q;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  assign blink_off = blink_q;
`else
  assign blink_off = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Stage 3: colour mux and output register
  // ---------------------------------------------------------------------------
  logic pix_on;

  assign pix_on = in_rect_s2 & char_pixels[3'd7 - bit_sel_s2] &
                  ~tim_s2.hblnk & ~tim_s2.vblnk & ~blink_off;

  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= tim_s2.hcount;
      vcount_out <= tim_s2.vcount;
      hsync_out  <= tim_s2.hsync;
      vsync_out  <= tim_s2.vsync;
      hblnk_out  <= tim_s2.hblnk;
      vblnk_out  <= tim_s2.vblnk;
      rgb_out    <= pix_on ? FG_COLOR : tim_s2.rgb;
    end
  end

endmodule

// File: tb/tb_draw_text_rect.sv
// -----------------------------------------------------------------------------
// tb_draw_text_rect
//
// Bench for draw_text_rect. It supplies the external text ROM (combinational)
// and font ROM (registered), drives one pixel per cycle, and predicts every
// output from the rectangle/cell arithmetic with a queue of expected pixels.
// Build with +define+TEXT_BLINK_EN to exercise the blink feature as well.
// -----------------------------------------------------------------------------
module tb_draw_text_rect;

  localparam int unsigned XPOS         = 100;
  localparam int unsigned YPOS         = 50;
  localparam int unsigned COLS         = 5;
  localparam int unsigned ROWS         = 2;
  localparam logic [11:0] FG           = 12'hF0A;
  localparam int unsigned BLINK_FRAMES = 2;

  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [7:0]  char_xy;
  logic [3:0]  char_line;
  logic [7:0]  char_pixels;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  draw_text_rect #(
    .XPOS(XPOS), .YPOS(YPOS), .COLS(COLS), .ROWS(ROWS),
    .FG_COLOR(FG), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .char_xy(char_xy), .char_line(char_line), .char_pixels(char_pixels),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 pclk = ~pclk;

  // ---------------------------------------------------------------------------
  // External ROMs. A per-pixel "force" lets directed steps pick the font row;
  // it travels one stage alongside the pixel so it meets that pixel's lookup.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] text_fn(input logic [7:0] a);
    return a * 8'd37 + 8'd11;
  endfunction

  function automatic logic [7:0] font_fn(input logic [7:0] code, input logic [3:0] line);
    return ((code ^ {line, line}) * 8'd13) + 8'h5A;
  endfunction

  logic       font_force = 1'b0;
  logic [7:0] font_val   = 8'h00;
  logic       force_s1   = 1'b0;
  logic [7:0] fval_s1    = 8'h00;

  always @(posedge pclk) begin
    force_s1    <= font_force;
    fval_s1     <= font_val;
    char_pixels <= force_s1 ? fval_s1 : font_fn(text_fn(char_xy), char_line);
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
    logic        fg;           // glyph pixel lit, before blink
    logic        blink_after;  // blink state once this pixel's vsync is seen
  } exp_t;

  exp_t       q[$];
  logic [7:0] exp_xy;
  logic [3:0] exp_line;
  bit         xy_valid = 1'b0;
  int         n_checks = 0;
  int         n_pass   = 0;

  // blink model state
  int  m_cnt   = 0;
  bit  m_blink = 1'b0;
  bit  m_vprev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One pixel per call: compare what is due, drive the new pixel, predict it.
  task automatic step(input logic r, input int h, input int v,
                      input logic hs, input logic vs, input logic hb, input logic vb,
                      input logic [11:0] c, input logic fe, input logic [7:0] fv);
    exp_t e;
    bit   ir;
    int   rx, ry;
    logic [7:0] addr, glyph;
    logic [3:0] line;
    @(negedge pclk);
    if (xy_valid) begin
      check("char_xy", char_xy, exp_xy);
      check("char_line", char_line, exp_line);
    end
    if (q.size() == 3) begin
      e = q[0];
      check("rgb_out", rgb_out, (e.fg && !q[1].blink_after) ? FG : e.rgb);
      check("hcount_out", hcount_out, e.h);
      check("vcount_out", vcount_out, e.v);
      check("sync_blank_out", {hsync_out, vsync_out, hblnk_out, vblnk_out},
            {e.hs, e.vs, e.hb, e.vb});
      void'(q.pop_front());
    end

    rst = r; hcount_in = 11'(h); vcount_in = 11'(v);
    hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb;
    rgb_in = c; font_force = fe; font_val = fv;

    if (r) begin
      foreach (q[i]) q[i] = '0;
      q.push_back('0);
      exp_xy = 8'h00; exp_line = 4'h0;
      m_cnt = 0; m_blink = 1'b0; m_vprev = 1'b0;
    end else begin
      ir = (h >= XPOS) && (h < XPOS + 8*COLS) && (v >= YPOS) && (v < YPOS + 16*ROWS);
      rx = h - XPOS;
      ry = v - YPOS;
      addr  = ir ? 8'((((ry / 16) % 16) * 16) + ((rx / 8) % 16)) : 8'h00;
      line  = ir ? 4'(ry % 16) : 4'h0;
      glyph = fe ? fv : font_fn(text_fn(addr), line);
`ifdef TEXT_BLINK_EN
      if (vs && !m_vprev) begin
        if (m_cnt == BLINK_FRAMES - 1) begin
          m_cnt = 0;
          m_blink = !m_blink;
        end else begin
          m_cnt++;
        end
      end
      m_vprev = vs;
`endif
      e.h = 11'(h); e.v = 11'(v);
      e.hs = hs; e.vs = vs; e.hb = hb; e.vb = vb;
      e.rgb = c;
      e.fg = ir && glyph[7 - (ir ? rx % 8 : 0)] && !hb && !vb;
      e.blink_after = m_blink;
      q.push_back(e);
      exp_xy = addr; exp_line = line;
    end
    xy_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 8'h00);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; hcount_in = '0; vcount_in = '0;
    hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0; rgb_in = '0;

    // Reset held for two cycles with random inputs.
    for (int i = 0; i < 2; i++)
      step(1'b1, 100 + i, 50, 1'($urandom), 1'($urandom), 1'b0, 1'b0,
           12'($urandom), 1'b1, 8'hFF);
    @(posedge pclk); #1;
    check("rst_rgb_out", rgb_out, 12'h000);
    check("rst_hcount_out", hcount_out, 11'd0);
    check("rst_vcount_out", vcount_out, 11'd0);
    check("rst_sync_blank", {hsync_out, vsync_out, hblnk_out, vblnk_out}, 4'h0);
    check("rst_char_xy", char_xy, 8'h00);

    // hcount_out tracks hcount_in after release.
    for (int i = 0; i < 6; i++)
      step(1'b0, 10 + i, 5, 1'b1, 1'b0, 1'b1, 1'b0, 12'(i * 3), 1'b0, 8'h00);

    // Address generation.
    step(1'b0, 117, 53, 1'b0, 1'b0, 1'b0, 1'b0, 12'h111, 1'b0, 8'h00);
    @(posedge pclk); #1;
    check("addr_117_53", char_xy, 8'h02);
    check("line_117_53", char_line, 4'd3);
    step(1'b0, 140, 53, 1'b0, 1'b0, 1'b0, 1'b0, 12'h222, 1'b0, 8'h00);
    @(posedge pclk); #1;
    check("addr_140_out", char_xy, 8'h00);
    step(1'b0, 139, 81, 1'b0, 1'b0, 1'b0, 1'b0, 12'h333, 1'b0, 8'h00);
    @(posedge pclk); #1;
    check("addr_139_81", char_xy, 8'h14);
    check("line_139_81", char_line, 4'd15);

    // Glyph pixel selection with font row 8'h80.
    step(1'b0, 100, 50, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 1'b1, 8'h80);
    step(1'b0, 101, 50, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456, 1'b1, 8'h80);
    step(1'b0, 107, 50, 1'b0, 1'b0, 1'b0, 1'b0, 12'h789, 1'b1, 8'h01);

    // Rectangle edges with a fully set font row.
    step(1'b0,  99, 60, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0A1, 1'b1, 8'hFF);
    step(1'b0, 100, 60, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0A2, 1'b1, 8'hFF);
    step(1'b0, 139, 60, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0A3, 1'b1, 8'hFF);
    step(1'b0, 140, 60, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0A4, 1'b1, 8'hFF);
    step(1'b0, 120, 49, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0A5, 1'b1, 8'hFF);
    step(1'b0, 120, 50, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0A6, 1'b1, 8'hFF);
    step(1'b0, 120, 81, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0A7, 1'b1, 8'hFF);
    step(1'b0, 120, 82, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0A8, 1'b1, 8'hFF);

    // Blanking inside the rectangle passes the colour through.
    step(1'b0, 120, 55, 1'b1, 1'b0, 1'b1, 1'b0, 12'h5B5, 1'b1, 8'hFF);
    step(1'b0, 121, 55, 1'b0, 1'b1, 1'b0, 1'b1, 12'h5B6, 1'b1, 8'hFF);
    idle(4);

    // Mid-line reset clears the whole pipeline on the next edge.
    step(1'b0, 110, 52, 1'b1, 1'b1, 1'b0, 1'b0, 12'hC01, 1'b1, 8'hFF);
    step(1'b0, 111, 52, 1'b1, 1'b1, 1'b0, 1'b0, 12'hC02, 1'b1, 8'hFF);
    step(1'b1, 112, 52, 1'b1, 1'b1, 1'b0, 1'b0, 12'hC03, 1'b1, 8'hFF);
    @(posedge pclk); #1;
    check("midrst_rgb_out", rgb_out, 12'h000);
    check("midrst_hcount_out", hcount_out, 11'd0);
    check("midrst_char_xy", char_xy, 8'h00);
    for (int i = 0; i < 5; i++)
      step(1'b0, 113 + i, 52, 1'b0, 1'b0, 1'b0, 1'b0, 12'(12'hD00 + i), 1'b1, 8'hFF);

`ifdef TEXT_BLINK_EN
    // Two vsync rising edges hide the text, two more bring it back.
    for (int phase = 0; phase < 3; phase++) begin
      for (int i = 0; i < 3; i++)
        step(1'b0, 104 + i, 51, 1'b0, 1'b0, 1'b0, 1'b0, 12'(12'hE00 + i), 1'b1, 8'hFF);
      for (int p = 0; p < 2; p++) begin
        step(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0, 8'h00);
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 8'h00);
      end
    end
`endif

    // Randomised traffic around the rectangle.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 99) == 0,
           $urandom_range(92, 148), $urandom_range(44, 88),
           1'($urandom), 1'($urandom),
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           12'($urandom), $urandom_range(0, 3) == 0, 8'($urandom));

    idle(4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
